// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FLT_OK       = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10
   } fault_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 RAM with one write port and one registered read port, filled with a NOP at power-up.
module imem_array
   import imem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter int          IDX_W     = $clog2(DEPTH),
   parameter logic [31:0] INIT_WORD = NOP_INST_DEF
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [31:0]      i_wdata,
   input  logic             i_re,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH] = '{default: INIT_WORD};

   // NOTE: the array and its read register have no reset, so they map onto block RAM and keep
   // their contents across rst_n.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/inst_mem_sync.sv
// Instruction memory with fetch request/response handshake, run-time program load and bulk clear.
module inst_mem_sync
   import imem_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fetch_valid,
   input  logic [ADDR_W-1:0]       fetch_pc,
   output logic                    fetch_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [31:0]             rsp_inst,
   output logic [ADDR_W-1:0]       rsp_pc,
   output logic [1:0]              rsp_fault,
   input  logic                    load_en,
   input  logic                    load_we,
   input  logic [ADDR_W-1:0]       load_addr,
   input  logic [31:0]             load_data,
   output logic [$clog2(DEPTH):0]  load_count,
   output logic                    load_err,
   input  logic                    clear_req,
   output logic                    busy
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_clr_idx;
   logic [IDX_W:0]    r_load_count;
   logic              r_load_err;
   logic              r_rsp_valid;
   logic [ADDR_W-1:0] r_rsp_pc;
   fault_t            r_rsp_fault;
   logic              r_rsp_nop;

   logic              w_accept;
   fault_t            w_fault;
   logic              w_load_ok;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [31:0]       w_wdata;
   logic [31:0]       w_rdata;

   assign fetch_ready = (r_state == RUN) && (!r_rsp_valid || rsp_ready);
   assign w_accept    = fetch_valid && fetch_ready;
   assign w_load_ok   = !(|load_addr[ADDR_W-1:IDX_W]);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_fault = FLT_OK;
      if (fetch_pc[1:0] != 2'b00) begin
         w_fault = FLT_MISALIGN;
      end else if (|fetch_pc[ADDR_W-1:IDX_W+2]) begin
         w_fault = FLT_RANGE;
      end
   end

   // Write port is shared: the clear engine owns it in CLEAR, the load port in LOAD.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = load_addr[IDX_W-1:0];
      w_wdata = load_data;
      if (rst_n) begin
         if (r_state == CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = NOP_INST;
         end else if (r_state == LOAD) begin
            w_we = load_we && w_load_ok;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RUN: begin
            if (clear_req) begin
               w_state_nxt = CLEAR;
            end else if (load_en) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD:    if (!load_en) w_state_nxt = RUN;
         CLEAR:   if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_clr_idx    <= '0;
         r_load_count <= '0;
         r_load_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == CLEAR) begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
         end
         if (r_state == RUN && w_state_nxt == LOAD) begin
            r_load_count <= '0;
            r_load_err   <= 1'b0;
         end else if (r_state == LOAD && load_we) begin
            if (!w_load_ok) begin
               r_load_err <= 1'b1;
            end else if (r_load_count != (IDX_W + 1)'(DEPTH)) begin
               r_load_count <= r_load_count + (IDX_W + 1)'(1);
            end
         end
      end
   end

   // Faulted responses never touch the array; r_rsp_nop substitutes the NOP on the output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_pc    <= '0;
         r_rsp_fault <= FLT_OK;
         r_rsp_nop   <= 1'b1;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rsp_pc    <= fetch_pc;
         r_rsp_fault <= w_fault;
         r_rsp_nop   <= (w_fault != FLT_OK);
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   imem_array #(
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .INIT_WORD (NOP_INST)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_accept && (w_fault == FLT_OK)),
      .i_raddr (fetch_pc[IDX_W+1:2]),
      .o_rdata (w_rdata)
   );

   assign rsp_valid  = r_rsp_valid;
   assign rsp_pc     = r_rsp_pc;
   assign rsp_fault  = r_rsp_fault;
   assign rsp_inst   = r_rsp_nop ? NOP_INST : w_rdata;
   assign load_count = r_load_count;
   assign load_err   = r_load_err;
   assign busy       = (r_state != RUN);

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: directed program/fault/load/clear cases plus random traffic.
module tb_inst_mem_sync;

   localparam int          DEPTH  = 1024;
   localparam int          ADDR_W = 32;
   localparam int          IDX_W  = 10;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          M_RUN = 0, M_LOAD = 1, M_CLEAR = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_valid;
   logic [ADDR_W-1:0] fetch_pc;
   logic              fetch_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_inst;
   logic [ADDR_W-1:0] rsp_pc;
   logic [1:0]        rsp_fault;
   logic              load_en;
   logic              load_we;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic [IDX_W:0]    load_count;
   logic              load_err;
   logic              clear_req;
   logic              busy;

   inst_mem_sync #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
      .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
      .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .load_count(load_count), .load_err(load_err),
      .clear_req(clear_req), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: memory image plus the observable state, advanced once per rising edge.
   logic [31:0] m_mem [DEPTH];
   int          m_mode, m_clr_pos, m_fault, m_count;
   bit          m_valid, m_err, m_acc;
   logic [31:0] m_inst, m_pc;

   function automatic int fault_of(input logic [31:0] pc);
      if (pc[1:0] != 2'b00) return 1;
      if ((pc >> 2) >= DEPTH) return 2;
      return 0;
   endfunction

   task automatic model_edge();
      bit ready;
      ready = (m_mode == M_RUN) && (!m_valid || rsp_ready);
      m_acc = fetch_valid && ready;
      if (!rst_n) begin
         m_mode = M_RUN; m_valid = 0; m_inst = NOP; m_pc = 0; m_fault = 0;
         m_count = 0; m_err = 0; m_acc = 0;
         return;
      end
      if (m_mode == M_LOAD && load_we) begin
         if (load_addr < DEPTH) begin
            m_mem[load_addr[IDX_W-1:0]] = load_data;
            if (m_count < DEPTH) m_count++;
         end else begin
            m_err = 1;
         end
      end
      if (m_mode == M_CLEAR) begin
         m_mem[m_clr_pos] = NOP;
         m_clr_pos++;
      end
      if (m_acc) begin
         m_valid = 1;
         m_pc    = fetch_pc;
         m_fault = fault_of(fetch_pc);
         m_inst  = (m_fault != 0) ? NOP : m_mem[fetch_pc[IDX_W+1:2]];
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      case (m_mode)
         M_RUN: begin
            if (clear_req) begin
               m_mode = M_CLEAR; m_clr_pos = 0;
            end else if (load_en) begin
               m_mode = M_LOAD; m_count = 0; m_err = 0;
            end
         end
         M_LOAD:  if (!load_en) m_mode = M_RUN;
         default: if (m_clr_pos == DEPTH) m_mode = M_RUN;
      endcase
   endtask

   task automatic check_outputs();
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_pc", rsp_pc, m_pc);
      check("rsp_fault", rsp_fault, m_fault);
      check("rsp_inst", rsp_inst, m_inst);
      check("busy", busy, m_mode != M_RUN);
      check("load_count", load_count, m_count);
      check("load_err", load_err, m_err);
   endtask

   // One clock: ready sampled at the falling edge, model advanced at the rising edge, outputs 1ns later.
   task automatic cycle();
      @(negedge clk);
      if (rst_n) check("fetch_ready", fetch_ready, (m_mode == M_RUN) && (!m_valid || rsp_ready));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle();
      fetch_valid = 0; fetch_pc = '0; rsp_ready = 1;
      load_en = 0; load_we = 0; load_addr = '0; load_data = '0; clear_req = 0;
   endtask

   task automatic fetch_one(input logic [31:0] pc);
      bit acc = 0;
      fetch_valid = 1; fetch_pc = pc; rsp_ready = 1;
      for (int g = 0; g < 8 && !acc; g++) begin
         cycle();
         acc = m_acc;
      end
      check("fetch_accept", acc, 1'b1);
      fetch_valid = 0;
   endtask

   task automatic load_words(input int first, input int n, input logic [31:0] base);
      load_en = 1; cycle();
      for (int i = 0; i < n; i++) begin
         load_we = 1; load_addr = first + i; load_data = base + i; cycle();
      end
      load_we = 0; load_en = 0; cycle();
   endtask

   logic [31:0] prog [9] = '{32'h0050_0093, 32'h00a0_0113, 32'h0011_2023, 32'h0001_2183,
                             32'h0030_8463, 32'h0010_8093, 32'h0000_0013, 32'hfe00_88e3,
                             32'h0020_8133};

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
      m_mode = M_RUN; m_clr_pos = 0; m_fault = 0; m_count = 0;
      m_valid = 0; m_err = 0; m_acc = 0; m_inst = NOP; m_pc = 0;
      idle();
      rst_n = 0;
      repeat (2) cycle();
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_inst", rsp_inst, NOP);
      check("rst_busy", busy, 1'b0);
      rst_n = 1;
      cycle();

      // Power-up contents
      fetch_one(32'h40);
      check("init_nop", rsp_inst, NOP);

      // Directed program, then fetch it back with a 3-cycle stall after PC 8
      load_en = 1; cycle();
      for (int i = 0; i < 9; i++) begin
         load_we = 1; load_addr = i; load_data = prog[i]; cycle();
      end
      check("prog_count", load_count, 9);
      load_we = 0; load_en = 0; cycle();
      begin
         int k = 0, stall = 0, guard = 0;
         bit stalled = 0;
         while (k < 9 && guard < 60) begin
            fetch_valid = 1; fetch_pc = 4 * k; rsp_ready = (stall == 0);
            cycle();
            guard++;
            if (stall > 0) begin
               check("stall_pc", rsp_pc, 32'd8);
               stall--;
            end
            if (m_acc) begin
               check("prog_word", rsp_inst, prog[k]);
               check("prog_fault", rsp_fault, 2'b00);
               k++;
            end
            if (m_valid && m_pc == 8 && !stalled) begin
               stalled = 1; stall = 3;
            end
         end
         check("prog_done", k, 9);
      end
      idle(); cycle();

      // Faults
      fetch_one(32'h6);
      check("mis_fault", rsp_fault, 2'b01);
      check("mis_inst", rsp_inst, NOP);
      fetch_one(4 * DEPTH);
      check("rng_fault", rsp_fault, 2'b10);
      check("rng_inst", rsp_inst, NOP);
      fetch_one(32'h1002);
      check("prio_fault", rsp_fault, 2'b01);
      idle(); cycle();

      // Out-of-range load writes
      load_en = 1; cycle();
      load_we = 1; load_addr = DEPTH; load_data = 32'hdead_beef; cycle();
      check("oor_err", load_err, 1'b1);
      check("oor_count", load_count, 0);
      load_addr = 32'h8000_0000; cycle();
      load_we = 0; load_en = 0; cycle();
      check("err_sticky", load_err, 1'b1);
      fetch_one(0);
      check("word0_kept", rsp_inst, prog[0]);
      idle(); cycle();

      // Saturating count over DEPTH+2 writes
      load_en = 1; cycle();
      check("entry_err_clr", load_err, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         load_we = 1; load_addr = i % DEPTH; load_data = $urandom; cycle();
      end
      check("sat_count", load_count, DEPTH);
      load_we = 0; load_en = 0; cycle();

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         int r;
         load_en     = (m_mode == M_LOAD) ? ($urandom % 8 != 0) : ($urandom % 16 == 0);
         load_we     = $urandom % 2;
         load_addr   = ($urandom % 12 == 0) ? DEPTH + ($urandom % 5) : $urandom % DEPTH;
         load_data   = $urandom;
         fetch_valid = ($urandom % 4 != 0);
         rsp_ready   = ($urandom % 4 != 0);
         r = $urandom % 10;
         if (r == 0)      fetch_pc = $urandom;
         else if (r == 1) fetch_pc = 4 * ($urandom % DEPTH) + 1 + $urandom % 3;
         else             fetch_pc = 4 * ($urandom % DEPTH);
         cycle();
      end
      idle(); repeat (3) cycle();

      // Clear with a simultaneous load request; stray inputs during CLEAR are ignored
      clear_req = 1; load_en = 1; cycle();
      clear_req = 0;
      begin
         int cnt = 0;
         while (busy === 1'b1 && cnt < 2 * DEPTH) begin
            cnt++;
            load_en   = (cnt < 4);
            clear_req = (cnt == 10);
            cycle();
         end
         check("clear_cycles", cnt, DEPTH);
      end
      idle(); cycle();
      begin
         int i = 0, guard = 0;
         while (i < DEPTH && guard < 2 * DEPTH) begin
            fetch_valid = 1; fetch_pc = 4 * i; rsp_ready = 1;
            cycle();
            guard++;
            if (m_acc) begin
               check("clr_word", rsp_inst, NOP);
               i++;
            end
         end
         check("clr_done", i, DEPTH);
      end
      idle(); cycle();

      // Reset during CLEAR once indices 0..4 have been written
      load_words(0, 8, 32'ha000_0000);
      clear_req = 1; cycle();
      clear_req = 0;
      repeat (5) cycle();
      check("mid_busy_pre", busy, 1'b1);
      rst_n = 0; cycle();
      rst_n = 1;
      check("mid_busy", busy, 1'b0);
      check("mid_valid", rsp_valid, 1'b0);
      cycle();
      for (int i = 0; i < 7; i++) begin
         fetch_one(4 * i);
         if (i < 5) check("mid_cleared", rsp_inst, NOP);
         if (i == 6) check("mid_kept", rsp_inst, 32'ha000_0006);
      end
      idle(); cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
